// File: rtl/uart_tx_gen_pkg.sv
// rtl/uart_tx_gen_pkg.sv - shared constants, FSM encoding and sizing helper for the UART transmitter
package uart_pkg;

   localparam logic [1:0] UART_PAR_NONE = 2'b00;
   localparam logic [1:0] UART_PAR_EVEN = 2'b01;
   localparam logic [1:0] UART_PAR_ODD  = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_PAR   = 3'd3,
      ST_STOP  = 3'd4
   } uart_state_e;

   // Number of characters needed to carry one request word.
   function automatic int uart_nchr(input int dat_w, input int chr_w);
      return (dat_w + chr_w - 1) / chr_w;
   endfunction

endpackage

// File: rtl/uart_tx_gen_if.sv
// rtl/uart_tx_gen_if.sv - push handshake, status and serial line of the UART transmitter
interface uart_tx_gen_if #(
   parameter int DAT_W  = 18,
   parameter int FIFO_D = 4
) ();
   import uart_pkg::*;

   localparam int CNT_W = $clog2(FIFO_D) + 1;

   logic             uart_req;
   logic             uart_ack;
   logic [DAT_W-1:0] uart_dat;
   logic [1:0]       uart_par;
   logic             uart_busy;
   logic [CNT_W-1:0] uart_cnt;
   logic             uart_sout;

   modport master (
      output uart_req, uart_dat, uart_par,
      input  uart_ack, uart_busy, uart_cnt, uart_sout
   );

   modport slave (
      input  uart_req, uart_dat, uart_par,
      output uart_ack, uart_busy, uart_cnt, uart_sout
   );

endinterface

// File: rtl/uart_tx_gen_fifo.sv
// rtl/uart_tx_gen_fifo.sv - word FIFO holding {parity mode, data} entries ahead of the serialiser
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int WIDTH = 20,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic             clk,
   input  logic             rst_x,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_dat_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] rd_dat_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CW-1:0]    cnt_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             push, pop;

   // Full is taken from the registered count, so a same-cycle pop never frees a slot early.
   assign full_o   = (cnt_q == CW'(DEPTH));
   assign empty_o  = (cnt_q == '0);
   assign cnt_o    = cnt_q;
   assign rd_dat_o = mem_q[rd_ptr_q];
   assign push     = wr_en_i & ~full_o;
   assign pop      = rd_en_i & ~empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_x) begin
      if (!rst_x) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wr_dat_i;
   end

endmodule

// File: rtl/uart_tx_gen.sv
// rtl/uart_tx_gen.sv - buffered UART transmitter splitting each word into LSB-first characters
module uart_tx_gen
   import uart_pkg::*;
#(
   parameter int DAT_W    = 18,
   parameter int CHR_W    = 8,
   parameter int STOP_W   = 2,
   parameter int BAUD_DIV = 4,
   parameter int FIFO_D   = 4
) (
   input  logic         clk,
   input  logic         rst_x,
   uart_tx_gen_if.slave tx_if
);

   localparam int NCHR   = uart_nchr(DAT_W, CHR_W);
   localparam int WORD_W = NCHR * CHR_W;
   localparam int ENT_W  = DAT_W + 2;
   localparam int CNT_W  = $clog2(FIFO_D) + 1;
   localparam int BW     = $clog2(BAUD_DIV);
   localparam int BCW    = 4;
   localparam int CIW    = $clog2(NCHR + 1);

   logic              fifo_pop, fifo_full, fifo_empty;
   logic [ENT_W-1:0]  fifo_dat;
   logic [CNT_W-1:0]  fifo_cnt;

   uart_state_e       state_q, state_d;
   logic [BW-1:0]     baud_q, baud_d;
   logic [BCW-1:0]    bit_q, bit_d;
   logic [CIW-1:0]    chr_q, chr_d;
   logic [WORD_W-1:0] word_q, word_d;
   logic [CHR_W-1:0]  sh_q, sh_d;
   logic [1:0]        pmode_q, pmode_d;
   logic              pbit_q, pbit_d;
   logic              sout_q, sout_d;

   logic              tick, par_on, load_new, load_next;
   logic [WORD_W-1:0] word_in;
   logic [1:0]        par_in;

   assign tx_if.uart_ack  = tx_if.uart_req & ~fifo_full;
   assign tx_if.uart_busy = (state_q != ST_IDLE);
   assign tx_if.uart_cnt  = fifo_cnt;
   assign tx_if.uart_sout = sout_q;

   uart_tx_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (FIFO_D)
   ) u_fifo (
      .clk      (clk),
      .rst_x    (rst_x),
      .wr_en_i  (tx_if.uart_ack),
      .wr_dat_i ({tx_if.uart_par, tx_if.uart_dat}),
      .rd_en_i  (fifo_pop),
      .rd_dat_o (fifo_dat),
      .full_o   (fifo_full),
      .empty_o  (fifo_empty),
      .cnt_o    (fifo_cnt)
   );

   // Zero-extending to a whole number of characters gives the padding of the last character.
   assign word_in = WORD_W'(fifo_dat[DAT_W-1:0]);
   assign par_in  = fifo_dat[DAT_W+1:DAT_W];
   assign tick    = (baud_q == BW'(BAUD_DIV - 1));
   assign par_on  = (pmode_q == UART_PAR_EVEN) || (pmode_q == UART_PAR_ODD);

   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bit_d     = bit_q;
      chr_d     = chr_q;
      word_d    = word_q;
      sh_d      = sh_q;
      pmode_d   = pmode_q;
      pbit_d    = pbit_q;
      sout_d    = 1'b1;
      fifo_pop  = 1'b0;
      load_new  = 1'b0;
      load_next = 1'b0;

      if (state_q != ST_IDLE) baud_d = tick ? '0 : baud_q + 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               load_new = 1'b1;
               state_d  = ST_START;
               baud_d   = '0;
            end
         end
         ST_START: begin
            if (tick) begin
               state_d = ST_DATA;
               bit_d   = '0;
            end
         end
         ST_DATA: begin
            if (tick) begin
               if (bit_q == BCW'(CHR_W - 1)) begin
                  state_d = par_on ? ST_PAR : ST_STOP;
                  bit_d   = '0;
               end else begin
                  bit_d = bit_q + 1'b1;
                  sh_d  = sh_q >> 1;
               end
            end
         end
         ST_PAR: begin
            if (tick) begin
               state_d = ST_STOP;
               bit_d   = '0;
            end
         end
         ST_STOP: begin
            if (tick) begin
               if (bit_q == BCW'(STOP_W - 1)) begin
                  // Chaining straight into the next character or word keeps the line gap-free.
                  if (chr_q != CIW'(NCHR - 1)) begin
                     state_d   = ST_START;
                     chr_d     = chr_q + 1'b1;
                     load_next = 1'b1;
                  end else if (!fifo_empty) begin
                     state_d  = ST_START;
                     fifo_pop = 1'b1;
                     load_new = 1'b1;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (load_new) begin
         pmode_d = par_in;
         chr_d   = '0;
         sh_d    = word_in[CHR_W-1:0];
         word_d  = word_in >> CHR_W;
         pbit_d  = (^word_in[CHR_W-1:0]) ^ (par_in == UART_PAR_ODD);
      end
      if (load_next) begin
         sh_d   = word_q[CHR_W-1:0];
         word_d = word_q >> CHR_W;
         pbit_d = (^word_q[CHR_W-1:0]) ^ (pmode_q == UART_PAR_ODD);
      end

      // The line level is decided from the next state so it changes on the bit boundary itself.
      case (state_d)
         ST_START: sout_d = 1'b0;
         ST_DATA:  sout_d = sh_d[0];
         ST_PAR:   sout_d = pbit_d;
         default:  sout_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_x) begin
      if (!rst_x) begin
         state_q <= ST_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         chr_q   <= '0;
         word_q  <= '0;
         sh_q    <= '0;
         pmode_q <= UART_PAR_NONE;
         pbit_q  <= 1'b0;
         sout_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         chr_q   <= chr_d;
         word_q  <= word_d;
         sh_q    <= sh_d;
         pmode_q <= pmode_d;
         pbit_q  <= pbit_d;
         sout_q  <= sout_d;
      end
   end

endmodule
